// File: rtl/sig_frame_sched.sv
// Frame-ring scheduler for the signal-saver DMA writer: arms the saver per frame,
// commits completed frames, and tracks produced vs. consumed frames for the consumer.
module sig_frame_sched #(
  parameter int unsigned FRAME_BYTES = 640,
  parameter int unsigned MAX_FRAMES  = 16,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned TIMEOUT     = 1048576
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cfg_base_addr,
  input  logic [CNT_W-1:0] cfg_num_frames,
  input  logic             cfg_continuous,
  input  logic             ctrl_start,
  input  logic             ctrl_stop,
  output logic             saver_start,
  output logic [31:0]      saver_addr,
  input  logic             saver_done,
  input  logic             frame_release,
  output logic             frame_irq,
  output logic [31:0]      rd_addr,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             full,
  output logic             err_timeout,
  output logic             err_underflow
);

  localparam int unsigned TMR_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_COMMIT,
    S_WAIT_SLOT
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      base_q;
  logic [CNT_W-1:0] depth_q;
  logic             cont_q;
  logic             stop_req;
  logic [CNT_W-1:0] wr_idx, rd_idx;
  logic [31:0]      wr_addr;
  logic [TMR_W-1:0] timer;

  logic             accept, commit, release_ok, underflow, timeout_hit, stop_now;
  logic             wr_wrap, rd_wrap;
  logic [CNT_W-1:0] depth_cfg, depth_nxt, pending_nxt, wr_idx_nxt, rd_idx_nxt;
  logic [31:0]      wr_addr_nxt, rd_addr_nxt;

  // Next-state and datapath next values
  always_comb begin
    state_nxt   = state;
    accept      = (state == S_IDLE) && ctrl_start;
    commit      = (state == S_COMMIT);
    timeout_hit = 1'b0;
    stop_now    = stop_req | ctrl_stop;
    // A release coinciding with a commit consumes the frame being committed.
    release_ok  = frame_release && ((pending != '0) || commit);
    underflow   = frame_release && (pending == '0) && !commit;

    if (cfg_num_frames == '0)
      depth_cfg = CNT_W'(1);
    else if (cfg_num_frames > CNT_W'(MAX_FRAMES))
      depth_cfg = CNT_W'(MAX_FRAMES);
    else
      depth_cfg = cfg_num_frames;
    depth_nxt = accept ? depth_cfg : depth_q;

    wr_wrap     = (wr_idx == depth_q - CNT_W'(1));
    rd_wrap     = (rd_idx == depth_q - CNT_W'(1));
    pending_nxt = pending;
    wr_idx_nxt  = wr_idx;
    wr_addr_nxt = wr_addr;
    rd_idx_nxt  = rd_idx;
    rd_addr_nxt = rd_addr;

    if (accept) begin
      pending_nxt = '0;
      wr_idx_nxt  = '0;
      rd_idx_nxt  = '0;
      wr_addr_nxt = cfg_base_addr;
      rd_addr_nxt = cfg_base_addr;
    end else begin
      if (commit) begin
        wr_idx_nxt  = wr_wrap ? '0 : wr_idx + CNT_W'(1);
        wr_addr_nxt = wr_wrap ? base_q : wr_addr + 32'(FRAME_BYTES);
      end
      if (release_ok) begin
        rd_idx_nxt  = rd_wrap ? '0 : rd_idx + CNT_W'(1);
        rd_addr_nxt = rd_wrap ? base_q : rd_addr + 32'(FRAME_BYTES);
      end
      if (commit && !release_ok)
        pending_nxt = pending + CNT_W'(1);
      else if (!commit && release_ok)
        pending_nxt = pending - CNT_W'(1);
    end

    case (state)
      S_IDLE:    if (accept) state_nxt = S_ARM;
      S_ARM:     state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (saver_done)
          state_nxt = S_COMMIT;
        else if ((TIMEOUT != 0) && (timer == TMR_W'(TIMEOUT - 1))) begin
          timeout_hit = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_COMMIT: begin
        if (stop_now || !cont_q)
          state_nxt = S_IDLE;
        else if (pending_nxt == depth_q)
          state_nxt = S_WAIT_SLOT;
        else
          state_nxt = S_ARM;
      end
      S_WAIT_SLOT: begin
        if (stop_now)
          state_nxt = S_IDLE;
        else if (pending_nxt != depth_q)
          state_nxt = S_ARM;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      base_q        <= '0;
      depth_q       <= '0;
      cont_q        <= 1'b0;
      stop_req      <= 1'b0;
      wr_idx        <= '0;
      rd_idx        <= '0;
      wr_addr       <= '0;
      timer         <= '0;
      saver_start   <= 1'b0;
      saver_addr    <= '0;
      frame_irq     <= 1'b0;
      rd_addr       <= '0;
      pending       <= '0;
      busy          <= 1'b0;
      full          <= 1'b0;
      err_timeout   <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      wr_idx  <= wr_idx_nxt;
      wr_addr <= wr_addr_nxt;
      rd_idx  <= rd_idx_nxt;
      rd_addr <= rd_addr_nxt;

      if (accept) begin
        base_q  <= cfg_base_addr;
        depth_q <= depth_cfg;
        cont_q  <= cfg_continuous;
      end

      if (accept)
        stop_req <= 1'b0;
      else if ((state != S_IDLE) && ctrl_stop)
        stop_req <= 1'b1;

      if (state == S_ARM)
        timer <= '0;
      else if (state == S_CAPTURE)
        timer <= timer + TMR_W'(1);

      saver_start <= (state_nxt == S_ARM);
      if (state_nxt == S_ARM)
        saver_addr <= wr_addr_nxt;
      frame_irq <= (state_nxt == S_COMMIT);
      busy      <= (state_nxt != S_IDLE);
      full      <= (depth_nxt != '0) && (pending_nxt == depth_nxt);

      if (accept)
        err_timeout <= 1'b0;
      else if (timeout_hit)
        err_timeout <= 1'b1;

      if (accept)
        err_underflow <= 1'b0;
      else if (underflow)
        err_underflow <= 1'b1;
    end
  end

endmodule
